// File: rtl/audio_pkg.sv
// Constants shared by the I2S capture (mic) and playback (speaker) paths.
// Both derive every audio clock and slot decode from one 9-bit counter.
package audio_pkg;
    localparam int AUDIO_W  = 16;
    localparam int CNT_W    = 9;
    localparam int SLOTS    = 32;
    localparam int SLOT_W   = 5;
    localparam int PHASE_W  = 4;

    localparam logic [SLOT_W-1:0] SLOT_LEFT_LSB  = 5'd16;
    localparam logic [SLOT_W-1:0] SLOT_RIGHT_LSB = 5'd0;

    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 8;
endpackage

// File: rtl/mic_ctrl_if.sv
// Sample stream from the mic capture path to the DSP/record consumer.
interface mic_ctrl_if;
    import audio_pkg::*;

    logic [AUDIO_W-1:0] sample_left;
    logic [AUDIO_W-1:0] sample_right;
    logic               sample_valid;
    logic               sample_ready;
    logic               overrun;

    modport master (
        output sample_left, sample_right, sample_valid, overrun,
        input  sample_ready
    );
    modport slave (
        input  sample_left, sample_right, sample_valid, overrun,
        output sample_ready
    );
endinterface

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter and I2S clock taps, shared by mic and speaker paths.
// Clocks come straight off counter flops, so they are glitch-free and low while idle.
module i2s_clk_gen
    import audio_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [CNT_W-1:0]   cnt,
    output logic               mclk,
    output logic               sck,
    output logic               lrck,
    output logic [SLOT_W-1:0]  slot,
    output logic [PHASE_W-1:0] phase
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    assign mclk  = cnt[MCLK_BIT];
    assign sck   = cnt[SCK_BIT];
    assign lrck  = cnt[LRCK_BIT];
    assign slot  = cnt[CNT_W-1:PHASE_W];
    assign phase = cnt[PHASE_W-1:0];
endmodule

// File: rtl/mic_ctrl.sv
// I2S master receiver for the audio ADC: drives MCLK/SCK/LRCK, deserialises
// ADC data and hands one left/right pair per 512-clk frame to the consumer.
module mic_ctrl
    import audio_pkg::*;
#(
    parameter int DATA_W       = AUDIO_W,
    parameter int SYNC_STAGES  = 2,
    parameter int SAMPLE_PHASE = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       audio_mclk,
    output logic       audio_sck,
    output logic       audio_lrck,
    input  logic       audio_sdout,
    mic_ctrl_if.master smp
);
    // Right LSB arrives one slot late (I2S delay), i.e. in slot 0 of the next frame.
    localparam logic [CNT_W-1:0] RIGHT_CAP_CNT = {SLOT_RIGHT_LSB, PHASE_W'(SAMPLE_PHASE)};

    logic [CNT_W-1:0]       cnt;
    logic [SLOT_W-1:0]      slot;
    logic [PHASE_W-1:0]     phase;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DATA_W-1:0]      shreg;
    logic [DATA_W-1:0]      left_hold;
    logic [DATA_W-1:0]      word;
    logic                   primed;
    logic                   sd_s;
    logic                   cap;

    i2s_clk_gen u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .cnt   (cnt),
        .mclk  (audio_mclk),
        .sck   (audio_sck),
        .lrck  (audio_lrck),
        .slot  (slot),
        .phase (phase)
    );

    assign sd_s = sync_q[SYNC_STAGES-1];
    assign cap  = en && (phase == PHASE_W'(SAMPLE_PHASE));
    assign word = {shreg[DATA_W-2:0], sd_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q           <= '0;
            shreg            <= '0;
            left_hold        <= '0;
            primed           <= 1'b0;
            smp.sample_left  <= '0;
            smp.sample_right <= '0;
            smp.sample_valid <= 1'b0;
            smp.overrun      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], audio_sdout};
            smp.overrun <= 1'b0;

            if (smp.sample_valid && smp.sample_ready)
                smp.sample_valid <= 1'b0;

            // A pending pair survives en=0; only the capture pipeline is flushed.
            if (!en) begin
                shreg     <= '0;
                left_hold <= '0;
                primed    <= 1'b0;
            end else if (cap) begin
                shreg <= word;
                if (slot == SLOT_LEFT_LSB) begin
                    left_hold <= word;
                    primed    <= 1'b1;
                end
                // Unprimed means the left half was never seen: drop the pair silently.
                if (cnt == RIGHT_CAP_CNT && primed) begin
                    if (!smp.sample_valid || smp.sample_ready) begin
                        smp.sample_left  <= left_hold;
                        smp.sample_right <= word;
                        smp.sample_valid <= 1'b1;
                    end else begin
                        smp.overrun <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mic_ctrl.sv
// Bench for mic_ctrl: frame-level ADC model plus a one-entry output model,
// compared against the DUT every cycle, with scenario checks on top.
module tb_mic_ctrl;
    import audio_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic ready = 1'b0;
    logic audio_sdout = 1'b0;
    logic audio_mclk, audio_sck, audio_lrck;

    mic_ctrl_if sif();
    assign sif.sample_ready = ready;

    mic_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .audio_mclk  (audio_mclk),
        .audio_sck   (audio_sck),
        .audio_lrck  (audio_lrck),
        .audio_sdout (audio_sdout),
        .smp         (sif.master)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at the most recent active edge.
    logic en_p = 1'b0, ready_p = 1'b0, rst_p = 1'b0;
    always @(posedge clk) begin
        en_p    = en;
        ready_p = ready;
        rst_p   = rst_n;
    end

    // Reference: frame position, pair being transmitted, and the output slot.
    logic [8:0]  mc = '0;
    logic [15:0] cur_l = '0, cur_r = '0, m_l = '0, m_r = '0;
    logic        cur_ok = 1'b0, m_valid = 1'b0, m_ovr = 1'b0, alt = 1'b0, v_prev = 1'b0;
    logic        done, full_block;
    int          mode = 0;
    int          xfers = 0;
    int          ovrs = 0;

    always @(negedge clk) begin
        int s;
        if (!rst_n || !rst_p) begin
            mc = '0; cur_l = '0; cur_r = '0; m_l = '0; m_r = '0;
            cur_ok = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; alt = 1'b0; v_prev = 1'b0;
        end else begin
            if (v_prev && ready_p) xfers++;
            // Right LSB of the in-flight pair lands at phase 12 of slot 0.
            done       = en_p && mc == 9'd12 && cur_ok;
            full_block = m_valid && !ready_p;
            m_ovr      = done && full_block;
            if (done && !full_block) begin
                m_l = cur_l; m_r = cur_r; m_valid = 1'b1;
            end else if (m_valid && ready_p) begin
                m_valid = 1'b0;
            end
            mc = en_p ? mc + 9'd1 : 9'd0;
            if (!en_p) begin
                cur_ok = 1'b0;
            end else if (mc == 9'd16) begin
                // Slot 1: the ADC starts a fresh left word.
                case (mode)
                    0: begin cur_l = 16'hA5C3; cur_r = 16'h1234; end
                    1: begin
                        cur_l = alt ? 16'hFFFF : 16'h8000;
                        cur_r = alt ? 16'h0001 : 16'h7FFF;
                        alt   = ~alt;
                    end
                    default: begin cur_l = 16'($urandom); cur_r = 16'($urandom); end
                endcase
                cur_ok = 1'b1;
            end
        end
        chk("valid",   32'(sif.sample_valid), 32'(m_valid));
        chk("left",    32'(sif.sample_left),  32'(m_l));
        chk("right",   32'(sif.sample_right), 32'(m_r));
        chk("overrun", 32'(sif.overrun),      32'(m_ovr));
        chk("mclk",    32'(audio_mclk),       32'(mc[1]));
        chk("sck",     32'(audio_sck),        32'(mc[3]));
        chk("lrck",    32'(audio_lrck),       32'(mc[8]));
        if (sif.overrun) ovrs++;
        v_prev = sif.sample_valid;
        s = int'(mc[8:4]);
        audio_sdout = (s == 0) ? cur_r[0] : (s <= 16) ? cur_l[16 - s] : cur_r[32 - s];
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_cnt(input logic [8:0] v);
        for (int i = 0; i < 1100; i++) begin
            if (mc == v) break;
            tick(1);
        end
        chk("wait_cnt", 32'(mc), 32'(v));
    endtask

    int x0, o0;

    initial begin
        ready = 1'b1;
        tick(5);
        chk("rst_valid", 32'(sif.sample_valid), 32'd0);
        chk("rst_left",  32'(sif.sample_left),  32'd0);
        chk("rst_right", 32'(sif.sample_right), 32'd0);
        chk("rst_ovr",   32'(sif.overrun),      32'd0);
        chk("rst_clks",  32'({audio_mclk, audio_sck, audio_lrck}), 32'd0);

        // Cold start, fixed pattern: first slot-0 pair is dropped.
        en = 1'b1; rst_n = 1'b1; x0 = xfers;
        tick(2560);
        chk("cold_pairs", 32'(xfers - x0), 32'd4);

        mode = 1;
        tick(2048);

        // Backpressure over three frames: one load, two dropped pairs.
        wait_cnt(9'd256);
        ready = 1'b0; o0 = ovrs;
        tick(1536);
        chk("bp_ovr",   32'(ovrs - o0), 32'd2);
        chk("bp_hold",  32'(sif.sample_valid), 32'd1);
        ready = 1'b1;
        tick(1);
        chk("bp_drain", 32'(sif.sample_valid), 32'd0);

        mode = 2;
        for (int i = 0; i < 2048; i++) begin
            ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        ready = 1'b1;
        tick(16);

        // en drop with a pair pending.
        wait_cnt(9'd256);
        ready = 1'b0;
        wait_cnt(9'd200);
        en = 1'b0;
        tick(1);
        chk("dis_clks",  32'({audio_mclk, audio_sck, audio_lrck}), 32'd0);
        chk("dis_valid", 32'(sif.sample_valid), 32'd1);
        tick(40);
        chk("dis_keep",  32'(sif.sample_valid), 32'd1);
        ready = 1'b1;
        tick(1);
        chk("dis_drain", 32'(sif.sample_valid), 32'd0);
        mode = 0; x0 = xfers;
        en = 1'b1;
        tick(1536);
        chk("reen_pairs", 32'(xfers - x0), 32'd2);

        // Async reset while a pair is held.
        mode = 2;
        wait_cnt(9'd100);
        ready = 1'b0;
        tick(512);
        wait_cnt(9'd300);
        chk("prerst_valid", 32'(sif.sample_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(sif.sample_valid), 32'd0);
        chk("arst_left",  32'(sif.sample_left),  32'd0);
        chk("arst_right", 32'(sif.sample_right), 32'd0);
        chk("arst_ovr",   32'(sif.overrun),      32'd0);
        tick(3);
        rst_n = 1'b1; ready = 1'b1; x0 = xfers; o0 = ovrs;
        tick(2560);
        chk("warm_pairs", 32'(xfers - x0), 32'd4);
        chk("warm_ovr",   32'(ovrs - o0),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
